// File: rtl/rfile_param.sv
// ---------------------------------------------------------------------------
// rfile_param
// Parametrised integer register file for the RV32I core. It has two read
// ports and one write port. Reads are registered, with an optional
// write-to-read bypass. After reset, or on clear_req, a clear sequencer
// zeroes every register one per cycle. It holds 'ready' low until the file
// is clean.
//
// Ports
//   clk        in   1     clock; all state changes on the rising edge
//   reset      in   1     asynchronous, active-low reset
//   rs1_addr   in   AW    read port 1 address
//   rs1_en     in   1     read port 1 enable (rs1_data updates only when high)
//   rs1_data   out  XLEN  read port 1 data, registered
//   rs2_addr   in   AW    read port 2 address
//   rs2_en     in   1     read port 2 enable
//   rs2_data   out  XLEN  read port 2 data, registered
//   rd_addr    in   AW    write address
//   rd_we      in   1     write enable
//   rd_data    in   XLEN  write data
//   clear_req  in   1     single-cycle request to re-zero the whole file
//   ready      out  1     1 = file usable, 0 = clear sequence in progress
// ---------------------------------------------------------------------------
module rfile_param #(
   parameter int XLEN     = 32,
   parameter int NREGS    = 32,
   parameter int AW       = 5,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [AW-1:0]   rs1_addr,
   input  logic            rs1_en,
   output logic [XLEN-1:0] rs1_data,
   input  logic [AW-1:0]   rs2_addr,
   input  logic            rs2_en,
   output logic [XLEN-1:0] rs2_data,
   input  logic [AW-1:0]   rd_addr,
   input  logic            rd_we,
   input  logic [XLEN-1:0] rd_data,
   input  logic            clear_req,
   output logic            ready
);

   typedef enum logic {S_CLEAR = 1'b0, S_READY = 1'b1} state_t;

   state_t            state_q, state_d;
   logic [AW-1:0]     clr_ptr_q, clr_ptr_d;
   logic [XLEN-1:0]   rs1_q, rs1_d;
   logic [XLEN-1:0]   rs2_q, rs2_d;
   logic [XLEN-1:0]   mem_q [NREGS];

   logic              mem_we;
   logic [AW-1:0]     mem_waddr;
   logic [XLEN-1:0]   mem_wdata;
   logic              wr_ok;

   // An address is backed by storage only when it lies inside the file.
   // Register 0 is excluded when it is hardwired to zero.
   function automatic logic addr_live(input logic [AW-1:0] a);
      return (int'(a) < NREGS) && !((ZERO_REG != 0) && (a == '0));
   endfunction

   // The read value in priority order: dead address -> 0, then the bypassed
   // write data, then the stored (pre-edge) contents.
   function automatic logic [XLEN-1:0] read_value(input logic [AW-1:0] a,
                                                  input logic          wr_ok_i,
                                                  input logic [AW-1:0] waddr,
                                                  input logic [XLEN-1:0] wdata,
                                                  input logic [XLEN-1:0] stored);
      if (!addr_live(a))
         return '0;
      if ((BYPASS != 0) && wr_ok_i && (waddr == a))
         return wdata;
      return stored;
   endfunction

   assign wr_ok = rd_we && addr_live(rd_addr);

   always_comb begin
      state_d   = state_q;
      clr_ptr_d = clr_ptr_q;
      rs1_d     = rs1_q;
      rs2_d     = rs2_q;
      mem_we    = 1'b0;
      mem_waddr = rd_addr;
      mem_wdata = rd_data;

      case (state_q)
         S_CLEAR: begin
            // The sequencer owns the write port. User writes, reads and
            // clear requests are ignored, and the read outputs hold zero.
            mem_we    = 1'b1;
            mem_waddr = clr_ptr_q;
            mem_wdata = '0;
            rs1_d     = '0;
            rs2_d     = '0;
            if (int'(clr_ptr_q) == NREGS - 1) begin
               state_d   = S_READY;
               clr_ptr_d = '0;
            end else begin
               clr_ptr_d = clr_ptr_q + 1'b1;
            end
         end
         S_READY: begin
            mem_we = wr_ok;
            if (rs1_en)
               rs1_d = read_value(rs1_addr, wr_ok, rd_addr, rd_data, mem_q[rs1_addr]);
            if (rs2_en)
               rs2_d = read_value(rs2_addr, wr_ok, rd_addr, rd_data, mem_q[rs2_addr]);
            // The write and reads of this cycle still complete; ready drops next cycle.
            if (clear_req) begin
               state_d   = S_CLEAR;
               clr_ptr_d = '0;
            end
         end
         default: begin
            state_d   = S_CLEAR;
            clr_ptr_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_CLEAR;
         clr_ptr_q <= '0;
         rs1_q     <= '0;
         rs2_q     <= '0;
      end else begin
         state_q   <= state_d;
         clr_ptr_q <= clr_ptr_d;
         rs1_q     <= rs1_d;
         rs2_q     <= rs2_d;
      end
   end

   // Storage is not reset; the clear sequencer zeroes it instead.
   always_ff @(posedge clk) begin
      if (mem_we)
         mem_q[mem_waddr] <= mem_wdata;
   end

   assign rs1_data = rs1_q;
   assign rs2_data = rs2_q;
   assign ready    = (state_q == S_READY);

endmodule

// File: tb/tb_rfile_param.sv
module tb_rfile_param;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [4:0]  a1 = '0, a2 = '0, ra = '0;
   logic        e1 = 1'b0, e2 = 1'b0, we = 1'b0, clr = 1'b0;
   logic [63:0] wd = '0;

   logic [31:0] d1_0, d2_0, d1_1, d2_1;
   logic [63:0] d1_2, d2_2;
   logic        rdy0, rdy1, rdy2;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   // Instance 0: default configuration (ZERO_REG=1, BYPASS=1)
   rfile_param #(.XLEN(32), .NREGS(32), .AW(5), .ZERO_REG(1), .BYPASS(1)) u0 (
      .clk(clk), .reset(rst_n),
      .rs1_addr(a1), .rs1_en(e1), .rs1_data(d1_0),
      .rs2_addr(a2), .rs2_en(e2), .rs2_data(d2_0),
      .rd_addr(ra), .rd_we(we), .rd_data(wd[31:0]),
      .clear_req(clr), .ready(rdy0));

   // Instance 1: no bypass, register 0 writable
   rfile_param #(.XLEN(32), .NREGS(32), .AW(5), .ZERO_REG(0), .BYPASS(0)) u1 (
      .clk(clk), .reset(rst_n),
      .rs1_addr(a1), .rs1_en(e1), .rs1_data(d1_1),
      .rs2_addr(a2), .rs2_en(e2), .rs2_data(d2_1),
      .rd_addr(ra), .rd_we(we), .rd_data(wd[31:0]),
      .clear_req(clr), .ready(rdy1));

   // Instance 2: 16 x 64-bit
   rfile_param #(.XLEN(64), .NREGS(16), .AW(4), .ZERO_REG(1), .BYPASS(1)) u2 (
      .clk(clk), .reset(rst_n),
      .rs1_addr(a1[3:0]), .rs1_en(e1), .rs1_data(d1_2),
      .rs2_addr(a2[3:0]), .rs2_en(e2), .rs2_data(d2_2),
      .rd_addr(ra[3:0]), .rd_we(we), .rd_data(wd),
      .clear_req(clr), .ready(rdy2));

   // ---------------- reference model ----------------
   int          nr [3] = '{32, 32, 16};
   bit          zr [3] = '{1'b1, 1'b0, 1'b1};
   bit          bp [3] = '{1'b1, 1'b0, 1'b1};
   logic [63:0] msk[3] = '{64'h0000_0000_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
   logic [63:0] m  [3][32];
   int          cd [3];          // clear cycles still to run; 0 = usable
   logic [63:0] x1 [3], x2 [3];  // expected read outputs

   function automatic logic [63:0] out1(int i);
      case (i)
         0: return {32'd0, d1_0};
         1: return {32'd0, d1_1};
         default: return d1_2;
      endcase
   endfunction

   function automatic logic [63:0] out2(int i);
      case (i)
         0: return {32'd0, d2_0};
         1: return {32'd0, d2_1};
         default: return d2_2;
      endcase
   endfunction

   function automatic logic rdy(int i);
      case (i)
         0: return rdy0;
         1: return rdy1;
         default: return rdy2;
      endcase
   endfunction

   function automatic logic [63:0] mread(int i, logic [4:0] a);
      int ad, wa;
      ad = int'(a) % nr[i];
      wa = int'(ra) % nr[i];
      if (zr[i] && ad == 0) return 64'd0;
      if (bp[i] && we && wa == ad) return wd & msk[i];
      return m[i][ad];
   endfunction

   function automatic void model_wipe(int i);
      cd[i] = nr[i];
      for (int j = 0; j < 32; j++) m[i][j] = 64'd0;
   endfunction

   task automatic tick();
      @(posedge clk);
      for (int i = 0; i < 3; i++) begin
         if (!rst_n) begin
            model_wipe(i);
            x1[i] = 64'd0; x2[i] = 64'd0;
         end else if (cd[i] > 0) begin
            cd[i]--;
            x1[i] = 64'd0; x2[i] = 64'd0;
         end else begin
            int wa;
            wa = int'(ra) % nr[i];
            if (e1) x1[i] = mread(i, a1);
            if (e2) x2[i] = mread(i, a2);
            if (we && !(zr[i] && wa == 0)) m[i][wa] = wd & msk[i];
            if (clr) model_wipe(i);
         end
      end
      #1;
   endtask

   task automatic idle();
      e1 = 1'b0; e2 = 1'b0; we = 1'b0; clr = 1'b0;
   endtask

   task automatic assert_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         model_wipe(i);
         x1[i] = 64'd0; x2[i] = 64'd0;
      end
      #1;
   endtask

   // Release reset and measure, per instance, the cycles until ready rises.
   task automatic release_and_time(string tag);
      int first [3];
      first = '{-1, -1, -1};
      rst_n = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         e1 = 1'b1; e2 = 1'b1; we = 1'b1; clr = 1'b1;  // ignored while clearing
         a1 = 5'($urandom); a2 = 5'($urandom); ra = 5'($urandom);
         wd = {$urandom, $urandom};
         if (k >= 16) begin we = 1'b0; clr = 1'b0; end
         tick();
         for (int i = 0; i < 3; i++) begin
            if (first[i] < 0 && rdy(i)) first[i] = k;
            if (first[i] < 0) begin
               checks++;
               if (out1(i) !== 64'd0 || out2(i) !== 64'd0) begin
                  failures++;
                  $display("FAIL %s_data_zero_while_clear inst%0d cyc%0d: rs1=%h rs2=%h expected 0", tag, i, k, out1(i), out2(i));
               end
            end
         end
      end
      idle();
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (first[i] !== nr[i]) begin
            failures++;
            $display("FAIL %s_ready_delay inst%0d: got %0d cycles, expected %0d", tag, i, first[i], nr[i]);
         end
      end
   endtask

   task automatic test_reset();
      assert_reset();
      checks++;
      if ({rdy0, rdy1, rdy2} !== 3'b000 || d1_0 !== 32'd0 || d2_0 !== 32'd0 || d1_2 !== 64'd0) begin
         failures++;
         $display("FAIL reset_state: ready=%b%b%b rs1=%h rs2=%h expected ready=000 data=0", rdy0, rdy1, rdy2, d1_0, d2_0);
      end
      tick(); tick();
      release_and_time("reset");
   endtask

   task automatic test_reads_after_clear();
      for (int r = 1; r < 32; r++) begin
         idle();
         e1 = 1'b1; e2 = 1'b1; a1 = 5'(r); a2 = 5'(31 - r + 1);
         tick();
         checks++;
         if (d1_0 !== 32'd0 || d2_0 !== 32'd0 || d1_2 !== x1[2] || d2_1 !== x2[1]) begin
            failures++;
            $display("FAIL post_clear_read x%0d: rs1=%h rs2=%h expected 0", r, d1_0, d2_0);
         end
      end
      idle();
   endtask

   task automatic test_write_read();
      idle();
      we = 1'b1; ra = 5'd5; wd = 64'h0123_4567_DEAD_BEEF;
      tick();
      idle();
      e1 = 1'b1; a1 = 5'd5;
      tick();
      checks++;
      if (d1_0 !== 32'hDEAD_BEEF || d1_1 !== 32'hDEAD_BEEF) begin
         failures++;
         $display("FAIL write_then_read32: got %h/%h expected deadbeef", d1_0, d1_1);
      end
      checks++;
      if (d1_2 !== 64'h0123_4567_DEAD_BEEF) begin
         failures++;
         $display("FAIL write_then_read64: got %h expected 01234567deadbeef", d1_2);
      end
      idle();
   endtask

   task automatic test_bypass();
      idle();
      we = 1'b1; ra = 5'd7; wd = 64'h0000_0000_AAAA_0000;
      tick();
      idle();
      we = 1'b1; ra = 5'd7; wd = 64'h0000_0000_1234_5678;
      e1 = 1'b1; e2 = 1'b1; a1 = 5'd7; a2 = 5'd7;
      tick();
      checks++;
      if (d1_0 !== 32'h1234_5678 || d2_0 !== 32'h1234_5678) begin
         failures++;
         $display("FAIL bypass_on: rs1=%h rs2=%h expected 12345678", d1_0, d2_0);
      end
      checks++;
      if (d1_1 !== 32'hAAAA_0000 || d2_1 !== 32'hAAAA_0000) begin
         failures++;
         $display("FAIL bypass_off: rs1=%h rs2=%h expected aaaa0000", d1_1, d2_1);
      end
      idle();
      e1 = 1'b1; a1 = 5'd7;
      tick();
      checks++;
      if (d1_1 !== 32'h1234_5678) begin
         failures++;
         $display("FAIL bypass_off_next_cycle: rs1=%h expected 12345678", d1_1);
      end
      idle();
   endtask

   task automatic test_zero_reg();
      idle();
      we = 1'b1; ra = 5'd0; wd = 64'hFFFF_FFFF_FFFF_FFFF;
      e2 = 1'b1; a2 = 5'd0;
      tick();
      checks++;
      if (d2_0 !== 32'd0 || d2_2 !== 64'd0) begin
         failures++;
         $display("FAIL x0_bypass_blocked: got %h/%h expected 0", d2_0, d2_2);
      end
      idle();
      e2 = 1'b1; a2 = 5'd0;
      tick();
      checks++;
      if (d2_0 !== 32'd0) begin
         failures++;
         $display("FAIL x0_hardwired: got %h expected 0", d2_0);
      end
      checks++;
      if (d2_1 !== 32'hFFFF_FFFF) begin
         failures++;
         $display("FAIL x0_writable: got %h expected ffffffff", d2_1);
      end
      idle();
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         a1  = 5'($urandom); a2 = 5'($urandom); ra = 5'($urandom);
         e1  = 1'($urandom); e2 = 1'($urandom); we = ($urandom_range(0, 3) != 0);
         wd  = {$urandom, $urandom};
         clr = ($urandom_range(0, 99) == 0);
         if ($urandom_range(0, 3) == 0) a2 = a1;
         if ($urandom_range(0, 3) == 0) ra = a1;
         tick();
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (out1(i) !== x1[i] || out2(i) !== x2[i] || rdy(i) !== (cd[i] == 0)) begin
               failures++;
               $display("FAIL random inst%0d cyc%0d: rs1=%h rs2=%h rdy=%b expected %h %h %b",
                        i, c, out1(i), out2(i), rdy(i), x1[i], x2[i], cd[i] == 0);
            end
         end
      end
      idle();
      // Let any clear still running finish before the next scenario.
      for (int k = 0; k < 40; k++) tick();
   endtask

   task automatic test_clear();
      int low;
      idle();
      for (int r = 1; r < 32; r++) begin
         we = 1'b1; ra = 5'(r); wd = {32'h5A5A_0000 + 32'(r), 32'h0101_0101 * 32'(r)};
         tick();
      end
      we = 1'b1; ra = 5'd3; wd = 64'h1; clr = 1'b1;
      tick();
      clr = 1'b0;
      low = -1;
      for (int k = 1; k <= 40; k++) begin
         we = 1'b1; ra = 5'($urandom_range(1, 31)); wd = {$urandom | 32'h1, $urandom | 32'h1};
         tick();
         if (rdy0) begin low = k; break; end
      end
      idle();
      checks++;
      if (low !== 32) begin
         failures++;
         $display("FAIL clear_req_ready_low: ready low %0d cycles, expected 32", low);
      end
      for (int r = 1; r < 32; r++) begin
         idle();
         e1 = 1'b1; e2 = 1'b1; a1 = 5'(r); a2 = 5'(r);
         tick();
         checks++;
         if (d1_0 !== 32'd0 || d2_1 !== 32'd0 || d1_2 !== x1[2]) begin
            failures++;
            $display("FAIL clear_req_contents x%0d: u0=%h u1=%h u2=%h expected 0 0 %h", r, d1_0, d2_1, d1_2, x1[2]);
         end
      end
      idle();
   endtask

   task automatic test_reset_mid_clear();
      idle();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      for (int k = 0; k < 10; k++) tick();
      assert_reset();
      checks++;
      if ({rdy0, rdy1, rdy2} !== 3'b000 || d1_0 !== 32'd0 || d2_1 !== 32'd0) begin
         failures++;
         $display("FAIL reset_mid_clear_state: ready=%b%b%b expected 000", rdy0, rdy1, rdy2);
      end
      tick();
      release_and_time("reset_mid_clear");
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         model_wipe(i);
         x1[i] = 64'd0; x2[i] = 64'd0;
      end
      test_reset();
      test_reads_after_clear();
      test_write_read();
      test_bypass();
      test_zero_reg();
      test_random();
      test_clear();
      test_reset_mid_clear();
      test_write_read();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
